// File: rtl/gf163_pkg.sv
// Shared definitions for the GF(2^163) multiplier: field size, reduction constant,
// FSM state encoding and register-file select codes.
// No logic beyond a small select-code filter function.
package gf163_pkg;

    localparam int M = 163;

    // f(x) = x^163 + x^7 + x^6 + x^3 + 1; x^163 folds back onto these low bits.
    localparam logic [M-1:0] F_RED = 163'hC9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_XA   = 3'b001;
    localparam logic [2:0] SEL_XB   = 3'b010;
    localparam logic [2:0] SEL_ZA   = 3'b011;
    localparam logic [2:0] SEL_ZB   = 3'b100;
    localparam logic [2:0] SEL_ZC   = 3'b101;
    localparam logic [2:0] SEL_SWAP = 3'b110;
    localparam logic [2:0] SEL_CLR  = 3'b111;

    // Only plain register writes may leave the multiplier; swap/clear and
    // undefined codes collapse to "no write" so the result is dropped.
    function automatic logic [2:0] sel_filter(input logic [2:0] sel);
        logic [2:0] r;
        r = SEL_NONE;
        if (sel == SEL_XA || sel == SEL_XB || sel == SEL_ZA ||
            sel == SEL_ZB || sel == SEL_ZC)
            r = sel;
        return r;
    endfunction

endpackage

// File: rtl/gf163_mac_step.sv
// One multiply-reduce step: o_acc = (i_acc * x mod f) ^ (i_bit ? i_a : 0).
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: i_acc/i_a 163-bit field elements, i_bit current multiplier bit,
//        o_acc updated accumulator.
module gf163_mac_step
    import gf163_pkg::*;
(
    input  logic [M-1:0] i_acc,
    input  logic [M-1:0] i_a,
    input  logic         i_bit,
    output logic [M-1:0] o_acc
);

    logic [M-1:0] w_shift;

    // Multiply by x; a carry out of bit 162 is replaced by the reduction constant.
    assign w_shift = {i_acc[M-2:0], 1'b0} ^ (i_acc[M-1] ? F_RED : '0);
    assign o_acc   = w_shift ^ (i_bit ? i_a : '0);

endmodule

// File: rtl/gf163_mult.sv
// Digit-serial MSB-first GF(2^163) multiplier, s = a*b mod f, DIGIT b-bits per cycle.
// Latency: done rises on the (N+1)th rising edge counting the edge that samples start.
// Backpressure: none; start is ignored while busy and re-accepted in the DONE cycle.
// Ports: clk/rst (sync, active-high); start, a, b, dst_sel request inputs;
//        busy, done, s (registered product), reg_select (write strobe while done).
module gf163_mult
    import gf163_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [162:0] a,
    input  logic [162:0] b,
    input  logic [2:0]   dst_sel,
    output logic         busy,
    output logic         done,
    output logic [162:0] s,
    output logic [2:0]   reg_select
);

    localparam int N  = (M + DIGIT - 1) / DIGIT;
    localparam int NB = N * DIGIT;
    localparam int CW = $clog2(N);

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic [M-1:0]    r_a;
    logic [NB-1:0]   r_b;
    logic [M-1:0]    r_acc;
    logic [M-1:0]    r_s;
    logic [2:0]      r_sel;
    logic [CW-1:0]   r_cnt;
    logic [M-1:0]    w_chain [DIGIT+1];

    // Chain of DIGIT steps consuming the top DIGIT bits of the shifting b copy.
    assign w_chain[0] = r_acc;
    for (genvar k = 0; k < DIGIT; k++) begin : g_step
        gf163_mac_step u_step (
            .i_acc (w_chain[k]),
            .i_a   (r_a),
            .i_bit (r_b[NB-1-k]),
            .o_acc (w_chain[k+1])
        );
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next   = ST_RUN;
                    w_accept = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_cnt == '0)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    w_next   = ST_RUN;
                    w_accept = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_s   <= '0;
            r_sel <= SEL_NONE;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= NB'(b);
            r_acc <= '0;
            r_sel <= dst_sel;
            r_cnt <= CW'(N - 1);
        end else if (r_state == ST_RUN) begin
            r_acc <= w_chain[DIGIT];
            r_b   <= r_b << DIGIT;
            r_cnt <= r_cnt - CW'(1);
            // Result register only changes on the transition into DONE.
            if (r_cnt == '0)
                r_s <= w_chain[DIGIT];
        end
    end

    assign busy       = (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign s          = r_s;
    assign reg_select = done ? sel_filter(r_sel) : SEL_NONE;

endmodule

// File: tb/tb_gf163_mult.sv
module tb_gf163_mult;

    logic         clk = 1'b0;
    logic         rst;
    logic         start1, start4, start8;
    logic [162:0] a, b;
    logic [2:0]   dst_sel;

    logic         busy1, done1, busy4, done4, busy8, done8;
    logic [162:0] s1, s4, s8;
    logic [2:0]   rs1, rs4, rs8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf163_mult #(.DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .dst_sel(dst_sel),
        .busy(busy1), .done(done1), .s(s1), .reg_select(rs1));
    gf163_mult #(.DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .dst_sel(dst_sel),
        .busy(busy4), .done(done4), .s(s4), .reg_select(rs4));
    gf163_mult #(.DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .dst_sel(dst_sel),
        .busy(busy8), .done(done8), .s(s8), .reg_select(rs8));

    // Reference: LSB-first shift-and-add over GF(2^163).
    function automatic logic [162:0] gf_mul(input logic [162:0] x, input logic [162:0] y);
        logic [162:0] r;
        logic [162:0] t;
        r = '0;
        t = x;
        for (int i = 0; i < 163; i++) begin
            if (y[i]) r = r ^ t;
            t = t[162] ? ({t[161:0], 1'b0} ^ 163'hC9) : {t[161:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[162:0];
    endfunction

    task automatic chk(input string tag, input logic [162:0] obs, input logic [162:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one DIGIT=1 op; returns edges counted from the start-sampling edge
    // (inclusive) to the edge that raised done, and cycles busy was seen high.
    task automatic run1(input logic [162:0] av, input logic [162:0] bv, input logic [2:0] sel,
                        output int lat, output int busyn);
        a = av; b = bv; dst_sel = sel; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 1;
        busyn = int'(busy1);
        while (!done1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            busyn += int'(busy1);
        end
    endtask

    initial begin
        int lat, busyn, lat2, cnt_done, cnt_sel, l4, l8, n;
        logic [162:0] av, bv, a2, b2, e4;
        logic [2:0] sel, g4s, g8s;
        logic [162:0] g4, g8;
        logic [162:0] one162;

        rst = 1'b1; start1 = 0; start4 = 0; start8 = 0;
        a = '0; b = '0; dst_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 163'(busy1), 163'(0));
        chk("rst_done", 163'(done1), 163'(0));
        chk("rst_regsel", 163'(rs1), 163'(0));
        chk("rst_s", s1, 163'(0));
        chk("rst_s4", s4, 163'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // a=1, b=1
        run1(163'd1, 163'd1, 3'b001, lat, busyn);
        chk("one_lat", 163'(lat), 163'(164));
        chk("one_busy_cycles", 163'(busyn), 163'(163));
        chk("one_s", s1, 163'd1);
        chk("one_regsel", 163'(rs1), 163'(3'b001));
        @(posedge clk); #1;
        chk("one_done_drop", 163'(done1), 163'(0));
        chk("one_regsel_drop", 163'(rs1), 163'(0));
        chk("one_s_hold", s1, 163'd1);

        // x^162 * x = x^163 = x^7+x^6+x^3+1
        one162 = '0;
        one162[162] = 1'b1;
        run1(one162, 163'h2, 3'b011, lat, busyn);
        chk("red_lat", 163'(lat), 163'(164));
        chk("red_s", s1, 163'hC9);
        chk("red_regsel", 163'(rs1), 163'(3'b011));
        @(posedge clk); #1;
        chk("red_regsel_drop", 163'(rs1), 163'(0));

        // a=0 still takes full latency and yields 0
        run1(163'd0, rand163(), 3'b010, lat, busyn);
        chk("zero_lat", 163'(lat), 163'(164));
        chk("zero_s", s1, 163'd0);

        // start held through RUN with changing operands
        av = rand163(); bv = rand163(); a2 = rand163(); b2 = rand163();
        a = av; b = bv; dst_sel = 3'b100; start1 = 1'b1;
        @(posedge clk); #1;
        a = a2; b = b2; dst_sel = 3'b101;
        lat = 1;
        while (!done1 && lat < 400) begin @(posedge clk); #1; lat++; end
        chk("hold_lat1", 163'(lat), 163'(164));
        chk("hold_s1", s1, gf_mul(av, bv));
        chk("hold_regsel1", 163'(rs1), 163'(3'b100));
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("hold_restart_busy", 163'(busy1), 163'(1));
        chk("hold_s1_kept", s1, gf_mul(av, bv));
        lat2 = 1;
        while (!done1 && lat2 < 400) begin @(posedge clk); #1; lat2++; end
        chk("hold_period", 163'(lat2), 163'(164));
        chk("hold_s2", s1, gf_mul(a2, b2));
        chk("hold_regsel2", 163'(rs1), 163'(3'b101));
        @(posedge clk); #1;

        // reset 50 cycles into RUN, with start also high during reset
        a = rand163(); b = rand163(); dst_sel = 3'b001; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        chk("abort_busy_before", 163'(busy1), 163'(1));
        rst = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start1 = 1'b0;
        chk("abort_busy", 163'(busy1), 163'(0));
        chk("abort_s", s1, 163'd0);
        chk("abort_regsel", 163'(rs1), 163'(0));
        cnt_done = 0; cnt_sel = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            cnt_done += int'(done1);
            if (rs1 != 3'b000) cnt_sel++;
            if (busy1) cnt_sel++;
        end
        chk("abort_no_done", 163'(cnt_done), 163'(0));
        chk("abort_no_write", 163'(cnt_sel), 163'(0));

        // swap code: result computed but not written
        av = rand163(); bv = rand163();
        run1(av, bv, 3'b110, lat, busyn);
        chk("swap_done", 163'(done1), 163'(1));
        chk("swap_regsel", 163'(rs1), 163'(0));
        chk("swap_s", s1, gf_mul(av, bv));
        @(posedge clk); #1;

        // DIGIT=4 and DIGIT=8 random sweep, run side by side
        for (int t = 0; t < 1000; t++) begin
            av = rand163(); bv = rand163();
            sel = 3'($urandom_range(1, 5));
            a = av; b = bv; dst_sel = sel;
            start4 = 1'b1; start8 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0; start8 = 1'b0;
            a = rand163(); b = rand163(); dst_sel = 3'b000;
            l4 = 0; l8 = 0; n = 1;
            g4 = '0; g8 = '0; g4s = '0; g8s = '0;
            while ((l4 == 0 || l8 == 0) && n < 100) begin
                if (l4 == 0 && done4) begin l4 = n; g4 = s4; g4s = rs4; end
                if (l8 == 0 && done8) begin l8 = n; g8 = s8; g8s = rs8; end
                if (l4 == 0 || l8 == 0) begin @(posedge clk); #1; n++; end
            end
            e4 = gf_mul(av, bv);
            chk("d4_lat", 163'(l4), 163'(42));
            chk("d8_lat", 163'(l8), 163'(22));
            chk("d4_s", g4, e4);
            chk("d8_s", g8, e4);
            chk("d4_regsel", 163'(g4s), 163'(sel));
            chk("d8_regsel", 163'(g8s), 163'(sel));
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
